ex_8_7_div: RTL and testbench

//  Sequential shift-subtract (restoring) binary divider. Inverse of the team's shift-add multiplier.

---
 rtl/ex_8_7_div_pkg.sv | 15 +
 rtl/ex_8_7_div_ctrl.sv | 69 ++++++
 rtl/ex_8_7_div.sv | 83 ++++++++
 tb/tb_ex_8_7_div.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ex_8_7_div_pkg.sv
// Shared types and helpers for the restoring divider.
package ex_8_7_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Width of the iteration counter: must hold the value dp_width.
  function automatic int unsigned cnt_width(input int unsigned dp_width);
    return $clog2(dp_width + 1);
  endfunction

endpackage

// File: rtl/ex_8_7_div_ctrl.sv
// Divider control: FSM, iteration counter and ready/done handshake.
module ex_8_7_div_ctrl
  import ex_8_7_div_pkg::*;
#(
  parameter int unsigned dp_width = 5
) (
  input  logic clock,
  input  logic reset_b,
  input  logic start,
  input  logic div_zero_c,
  input  logic overflow_c,
  output logic load_c,
  output logic shift_sub_c,
  output logic set_flag_c,
  output logic ready,
  output logic done
);

  localparam int unsigned p_width = cnt_width(dp_width);

  state_t             state, state_next;
  logic [p_width-1:0] p, p_next;

  // State, counter and registered handshake outputs.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state <= S_IDLE;
      p     <= '0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      p     <= p_next;
      ready <= (state_next == S_IDLE);
      done  <= (state_next == S_DONE);
    end
  end

  // Next-state, counter update and datapath controls.
  always_comb begin
    state_next  = state;
    p_next      = p;
    load_c      = 1'b0;
    shift_sub_c = 1'b0;
    set_flag_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load_c = 1'b1;
          p_next = p_width'(dp_width);
          if (div_zero_c || overflow_c) begin
            set_flag_c = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        shift_sub_c = 1'b1;
        p_next      = p - p_width'(1);
        if (p == p_width'(1)) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/ex_8_7_div.sv
// Sequential restoring divider: 2n-bit dividend / n-bit divisor, one quotient bit per clock.
module ex_8_7_div
  import ex_8_7_div_pkg::*;
#(
  parameter int unsigned dp_width = 5
) (
  input  logic                  clock,
  input  logic                  reset_b,
  input  logic                  start,
  input  logic [2*dp_width-1:0] dividend,
  input  logic [dp_width-1:0]   divisor,
  output logic [dp_width-1:0]   quotient,
  output logic [dp_width-1:0]   remainder,
  output logic                  ready,
  output logic                  done,
  output logic                  overflow,
  output logic                  div_zero,
  output logic [dp_width-1:0]   A,
  output logic [dp_width-1:0]   B,
  output logic [dp_width-1:0]   Q,
  output logic                  E
);

  logic                load_c, shift_sub_c, set_flag_c;
  logic                div_zero_c, overflow_c;
  logic [dp_width:0]   rem_sh_c;
  logic [dp_width-1:0] diff_c;
  logic                ge_c;

  // Error detection on the operands presented with start.
  assign div_zero_c = (divisor == '0);
  assign overflow_c = !div_zero_c && (dividend[2*dp_width-1:dp_width] >= divisor);

  // (n+1)-bit partial remainder after the shift, so the compare never loses the carry-out.
  assign rem_sh_c = {A, Q[dp_width-1]};
  assign ge_c     = (rem_sh_c >= {1'b0, B});
  assign diff_c   = dp_width'(rem_sh_c - {1'b0, B});

  assign quotient  = Q;
  assign remainder = A;

  ex_8_7_div_ctrl #(.dp_width(dp_width)) u_ctrl (
    .clock       (clock),
    .reset_b     (reset_b),
    .start       (start),
    .div_zero_c  (div_zero_c),
    .overflow_c  (overflow_c),
    .load_c      (load_c),
    .shift_sub_c (shift_sub_c),
    .set_flag_c  (set_flag_c),
    .ready       (ready),
    .done        (done)
  );

  // Datapath registers: operand load, shift-subtract iteration and error flags.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      A        <= '0;
      B        <= '0;
      Q        <= '0;
      E        <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else if (load_c) begin
      A        <= dividend[2*dp_width-1:dp_width];
      Q        <= dividend[dp_width-1:0];
      B        <= divisor;
      E        <= 1'b0;
      div_zero <= set_flag_c & div_zero_c;
      overflow <= set_flag_c & overflow_c;
    end else if (shift_sub_c) begin
      E <= 1'b0;
      if (ge_c) begin
        A <= diff_c;
        Q <= {Q[dp_width-2:0], 1'b1};
      end else begin
        A <= rem_sh_c[dp_width-1:0];
        Q <= {Q[dp_width-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_ex_8_7_div.sv
// Self-checking bench for ex_8_7_div (dp_width=5) against an arithmetic reference model.
module tb_ex_8_7_div;

  localparam int unsigned n = 5;

  logic           clock, reset_b, start;
  logic [2*n-1:0] dividend;
  logic [n-1:0]   divisor;
  logic [n-1:0]   quotient, remainder, A, B, Q;
  logic           ready, done, overflow, div_zero, E;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ex_8_7_div #(.dp_width(n)) dut (
    .clock     (clock),
    .reset_b   (reset_b),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .ready     (ready),
    .done      (done),
    .overflow  (overflow),
    .div_zero  (div_zero),
    .A         (A),
    .B         (B),
    .Q         (Q),
    .E         (E)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Present an operation, then count edges from the load edge until done is seen.
  task automatic run_op(input int unsigned dd, input int unsigned dv, output int unsigned edges);
    @(negedge clock);
    dividend = (2*n)'(dd);
    divisor  = n'(dv);
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    edges = 1;
    while (!done && edges < 40) begin
      @(posedge clock);
      #1 edges++;
    end
  endtask

  // Reference: plain integer division with the documented error classes.
  task automatic run_and_check(input int unsigned dd, input int unsigned dv);
    int unsigned edges, exp_q, exp_r;
    bit          exp_dz, exp_ov;
    exp_dz = (dv == 0);
    exp_ov = !exp_dz && ((dd / dv) >= (1 << n));
    exp_q  = exp_dz ? 0 : dd / dv;
    exp_r  = exp_dz ? 0 : dd % dv;
    run_op(dd, dv, edges);
    check($sformatf("latency %0d/%0d", dd, dv), edges, (exp_dz || exp_ov) ? 1 : n + 1);
    check($sformatf("div_zero %0d/%0d", dd, dv), div_zero, exp_dz);
    check($sformatf("overflow %0d/%0d", dd, dv), overflow, exp_ov);
    if (!exp_dz && !exp_ov) begin
      check($sformatf("quotient %0d/%0d", dd, dv), quotient, exp_q);
      check($sformatf("remainder %0d/%0d", dd, dv), remainder, exp_r);
      check($sformatf("B hold %0d/%0d", dd, dv), B, dv);
    end
    @(posedge clock);
    #1;
    check("done one cycle", done, 0);
    check("ready after done", ready, 1);
  endtask

  initial begin
    int unsigned edges;
    bit          done_seen;
    reset_b  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset ready", ready, 1);
    check("reset done", done, 0);
    check("reset A", A, 0);
    check("reset B", B, 0);
    check("reset Q", Q, 0);
    check("reset E", E, 0);
    check("reset flags", {overflow, div_zero}, 0);
    @(negedge clock) reset_b = 1'b1;

    // Directed cases, including the boundaries.
    run_and_check(100, 7);
    run_and_check(991, 31);
    run_and_check(0, 5);
    run_and_check(77, 0);
    run_and_check(1023, 0);
    run_and_check(1023, 31);
    run_and_check(31, 1);
    run_and_check(32, 1);
    run_and_check(1023, 1);

    // Start while busy is ignored.
    @(negedge clock);
    dividend = 10'd100;
    divisor  = 5'd7;
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    dividend = 10'd500;
    divisor  = 5'd3;
    start    = 1'b1;
    @(negedge clock) start = 1'b0;
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clock);
      #1 edges++;
    end
    check("busy done seen", done, 1);
    check("busy quotient", quotient, 14);
    check("busy remainder", remainder, 2);
    check("busy B", B, 7);
    @(posedge clock);
    #1 check("busy ready", ready, 1);

    // Reset in the middle of an operation aborts without done.
    @(negedge clock);
    dividend = 10'd100;
    divisor  = 5'd7;
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_b = 1'b0;
    #1;
    check("abort ready", ready, 1);
    check("abort done", done, 0);
    check("abort ABQ", {A, B, Q}, 0);
    check("abort E", E, 0);
    check("abort flags", {overflow, div_zero}, 0);
    @(negedge clock) reset_b = 1'b1;
    done_seen = 1'b0;
    repeat (8) begin
      @(posedge clock);
      #1 if (done) done_seen = 1'b1;
    end
    check("abort no done", done_seen, 0);
    run_and_check(100, 7);

    // Randomized operands, with a bias towards non-overflowing dividends.
    for (int i = 0; i < 1500; i++) begin
      int unsigned dv, dd;
      dv = $urandom_range(0, 31);
      if ((i % 3 != 0) && dv != 0)
        dd = $urandom_range(0, dv * 32 - 1);
      else
        dd = $urandom_range(0, 1023);
      run_and_check(dd, dv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
